// File: rtl/cdma_sync_fifo_if.sv
// Handshake bundle for cdma_sync_fifo: write/read requests, flush, data, status and error flags.
interface cdma_sync_fifo_if #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             flush;
    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             rd_en;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic             full;
    logic             empty;
    logic             afull;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;

    modport master (
        output flush, wr_en, wr_data, rd_en,
        input  rd_data, rd_valid, full, empty, afull, count, overflow, underflow
    );

    modport slave (
        input  flush, wr_en, wr_data, rd_en,
        output rd_data, rd_valid, full, empty, afull, count, overflow, underflow
    );
endinterface

// File: rtl/cdma_sync_fifo.sv
// Single-clock FIFO for router port buffering: registered read, occupancy flags,
// sticky overflow/underflow and a synchronous flush that outranks reads and writes.
module cdma_sync_fifo #(
    parameter int WIDTH     = 4,
    parameter int DEPTH     = 4,
    parameter int AFULL_LVL = 3
) (
    input logic             clk,
    input logic             rst,
    cdma_sync_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic [WIDTH-1:0] rd_data_q;
    logic             rd_valid_q;
    logic             overflow_q;
    logic             underflow_q;

    logic full_c;
    logic empty_c;
    logic afull_c;
    logic wr_acc;
    logic rd_acc;
    logic wr_go;
    logic rd_go;

    // Status flags decode the registered count only, so they never follow input glitches.
    assign full_c  = (count_q == CW'(DEPTH));
    assign empty_c = (count_q == '0);
    assign afull_c = (count_q >= CW'(AFULL_LVL));

    // A full FIFO rejects the write even when a read is accepted in the same cycle.
    assign wr_acc = bus.wr_en & ~full_c;
    assign rd_acc = bus.rd_en & ~empty_c;
    assign wr_go  = wr_acc & ~bus.flush;
    assign rd_go  = rd_acc & ~bus.flush;

    always_comb begin
        // NOTE: count_d gets its default before the case so no path leaves it unassigned (no latch).
        count_d = count_q;
        case ({wr_go, rd_go})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: the storage array has no reset; contents are only meaningful behind the pointers.
    always_ff @(posedge clk) begin
        if (wr_go) begin
            mem[wr_ptr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (bus.flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            if (wr_go) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_go) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count_q <= count_d;
        end
    end

    // rd_data holds its last word across idle cycles and flush; only reset clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_go;
            if (rd_go) begin
                rd_data_q <= mem[rd_ptr];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (bus.flush) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (bus.wr_en && full_c) begin
                overflow_q <= 1'b1;
            end
            if (bus.rd_en && empty_c) begin
                underflow_q <= 1'b1;
            end
        end
    end

    assign bus.rd_data   = rd_data_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.full      = full_c;
    assign bus.empty     = empty_c;
    assign bus.afull     = afull_c;
    assign bus.count     = count_q;
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
endmodule

// File: tb/tb_cdma_sync_fifo.sv
// Directed vector table on a 4x4 FIFO plus reset and randomized scoreboard runs on a 16x8 instance.
module tb_cdma_sync_fifo;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    cdma_sync_fifo_if #(.WIDTH(4), .DEPTH(4))  bus4 ();
    cdma_sync_fifo_if #(.WIDTH(8), .DEPTH(16)) bus16 ();

    cdma_sync_fifo #(.WIDTH(4), .DEPTH(4), .AFULL_LVL(3)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    cdma_sync_fifo #(.WIDTH(8), .DEPTH(16), .AFULL_LVL(12)) u_dut16 (
        .clk (clk),
        .rst (rst),
        .bus (bus16)
    );

    typedef struct {
        int fl;
        int wr;
        int rd;
        int din;
        int cnt;
        int full;
        int empty;
        int afull;
        int rv;
        int rdd;
        int ov;
        int un;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40) begin
                $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
            end
        end
    endtask

    task automatic v(input int fl, input int wr, input int rd, input int din, input int cnt,
                     input int full, input int empty, input int afull, input int rv,
                     input int rdd, input int ov, input int un);
        vec_t e;
        e.fl = fl; e.wr = wr; e.rd = rd; e.din = din; e.cnt = cnt; e.full = full;
        e.empty = empty; e.afull = afull; e.rv = rv; e.rdd = rdd; e.ov = ov; e.un = un;
        vecs.push_back(e);
    endtask

    task automatic check4(input string tag, input vec_t e);
        check({tag, ".count"},     32'(bus4.count),     32'(e.cnt));
        check({tag, ".full"},      32'(bus4.full),      32'(e.full));
        check({tag, ".empty"},     32'(bus4.empty),     32'(e.empty));
        check({tag, ".afull"},     32'(bus4.afull),     32'(e.afull));
        check({tag, ".rd_valid"},  32'(bus4.rd_valid),  32'(e.rv));
        check({tag, ".rd_data"},   32'(bus4.rd_data),   32'(e.rdd));
        check({tag, ".overflow"},  32'(bus4.overflow),  32'(e.ov));
        check({tag, ".underflow"}, 32'(bus4.underflow), 32'(e.un));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] model[$];
    logic [7:0] exp_word;
    logic [7:0] din8;
    int         mcnt;
    bit         w, r, wacc, racc, mov, mun;
    vec_t       e;

    initial begin
        //  fl wr rd din  cnt F  E  AF rv rdd ov un
        v(0, 0, 0, 'h0, 0, 0, 1, 0, 0, 'h0, 0, 0);   // idle after reset
        v(0, 0, 0, 'h0, 0, 0, 1, 0, 0, 'h0, 0, 0);
        v(0, 0, 0, 'h0, 0, 0, 1, 0, 0, 'h0, 0, 0);
        v(0, 1, 0, 'hA, 1, 0, 0, 0, 0, 'h0, 0, 0);   // fill
        v(0, 1, 0, 'hB, 2, 0, 0, 0, 0, 'h0, 0, 0);
        v(0, 1, 0, 'hC, 3, 0, 0, 1, 0, 'h0, 0, 0);
        v(0, 1, 0, 'hD, 4, 1, 0, 1, 0, 'h0, 0, 0);
        v(0, 1, 0, 'hE, 4, 1, 0, 1, 0, 'h0, 1, 0);   // write while full
        v(0, 0, 1, 'h0, 3, 0, 0, 1, 1, 'hA, 1, 0);   // drain
        v(0, 0, 1, 'h0, 2, 0, 0, 0, 1, 'hB, 1, 0);
        v(0, 0, 1, 'h0, 1, 0, 0, 0, 1, 'hC, 1, 0);
        v(0, 0, 1, 'h0, 0, 0, 1, 0, 1, 'hD, 1, 0);
        v(0, 0, 1, 'h0, 0, 0, 1, 0, 0, 'hD, 1, 1);   // read while empty
        v(0, 0, 0, 'h0, 0, 0, 1, 0, 0, 'hD, 1, 1);
        v(1, 0, 0, 'h0, 0, 0, 1, 0, 0, 'hD, 0, 0);   // flush clears flags
        v(0, 1, 0, 'h1, 1, 0, 0, 0, 0, 'hD, 0, 0);
        v(0, 1, 0, 'h2, 2, 0, 0, 0, 0, 'hD, 0, 0);
        v(0, 1, 1, 'h5, 2, 0, 0, 0, 1, 'h1, 0, 0);   // simultaneous, pointers wrap
        v(0, 1, 1, 'h6, 2, 0, 0, 0, 1, 'h2, 0, 0);
        v(0, 1, 1, 'h7, 2, 0, 0, 0, 1, 'h5, 0, 0);
        v(0, 1, 1, 'h8, 2, 0, 0, 0, 1, 'h6, 0, 0);
        v(0, 1, 1, 'h9, 2, 0, 0, 0, 1, 'h7, 0, 0);
        v(0, 1, 1, 'hA, 2, 0, 0, 0, 1, 'h8, 0, 0);
        v(0, 1, 0, 'hB, 3, 0, 0, 1, 0, 'h8, 0, 0);
        v(0, 1, 0, 'hC, 4, 1, 0, 1, 0, 'h8, 0, 0);
        v(0, 1, 1, 'hD, 3, 0, 0, 1, 1, 'h9, 1, 0);   // full: write rejected, read proceeds
        v(0, 0, 1, 'h0, 2, 0, 0, 0, 1, 'hA, 1, 0);
        v(0, 0, 1, 'h0, 1, 0, 0, 0, 1, 'hB, 1, 0);
        v(0, 0, 1, 'h0, 0, 0, 1, 0, 1, 'hC, 1, 0);
        v(0, 1, 1, 'hE, 1, 0, 0, 0, 0, 'hC, 1, 1);   // empty: read rejected, write proceeds
        v(0, 0, 1, 'h0, 0, 0, 1, 0, 1, 'hE, 1, 1);
        v(0, 1, 0, 'h1, 1, 0, 0, 0, 0, 'hE, 1, 1);
        v(0, 1, 0, 'h2, 2, 0, 0, 0, 0, 'hE, 1, 1);
        v(0, 1, 0, 'h3, 3, 0, 0, 1, 0, 'hE, 1, 1);
        v(1, 1, 1, 'hF, 0, 0, 1, 0, 0, 'hE, 0, 0);   // flush beats wr/rd
        v(0, 1, 0, 'h7, 1, 0, 0, 0, 0, 'hE, 0, 0);
        v(0, 0, 1, 'h0, 0, 0, 1, 0, 1, 'h7, 0, 0);

        bus4.flush = 1'b0;  bus4.wr_en = 1'b0;  bus4.rd_en = 1'b0;  bus4.wr_data = '0;
        bus16.flush = 1'b0; bus16.wr_en = 1'b0; bus16.rd_en = 1'b0; bus16.wr_data = '0;

        // Asynchronous reset asserted mid-cycle, visible before any clock edge.
        #3 rst = 1'b1;
        #1;
        e = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
        check4("async_reset", e);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;

        foreach (vecs[i]) begin
            bus4.flush   = vecs[i].fl[0];
            bus4.wr_en   = vecs[i].wr[0];
            bus4.rd_en   = vecs[i].rd[0];
            bus4.wr_data = 4'(vecs[i].din);
            tick();
            check4($sformatf("v%0d", i), vecs[i]);
        end

        // Reset mid-operation discards contents; the next write must land at address 0.
        bus4.flush = 1'b0; bus4.rd_en = 1'b0; bus4.wr_en = 1'b1; bus4.wr_data = 4'h9;
        tick();
        tick();
        bus4.wr_en = 1'b0;
        check("pre_reset.count", 32'(bus4.count), 32'd2);
        #3 rst = 1'b1;
        #1;
        e = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
        check4("mid_reset", e);
        @(posedge clk);
        #2 rst = 1'b0;
        bus4.wr_en = 1'b1; bus4.wr_data = 4'h3;
        tick();
        check("post_reset_wr.count", 32'(bus4.count), 32'd1);
        bus4.wr_en = 1'b0; bus4.rd_en = 1'b1;
        tick();
        bus4.rd_en = 1'b0;
        check("post_reset_rd.rd_valid", 32'(bus4.rd_valid), 32'd1);
        check("post_reset_rd.rd_data",  32'(bus4.rd_data),  32'h3);
        check("post_reset_rd.empty",    32'(bus4.empty),    32'd1);

        // Randomized traffic against a queue model on the 16-deep instance.
        mcnt = 0; mov = 1'b0; mun = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            w    = ($urandom_range(0, 1) == 1);
            r    = ($urandom_range(0, 1) == 1);
            din8 = 8'($urandom);
            wacc = w && (mcnt < 16);
            racc = r && (mcnt > 0);
            if (w && mcnt == 16) mov = 1'b1;
            if (r && mcnt == 0)  mun = 1'b1;
            bus16.wr_en = w; bus16.rd_en = r; bus16.wr_data = din8;
            tick();
            check("sweep.rd_valid", 32'(bus16.rd_valid), 32'(racc));
            if (racc) begin
                exp_word = model.pop_front();
                check("sweep.rd_data", 32'(bus16.rd_data), 32'(exp_word));
            end
            if (wacc) model.push_back(din8);
            mcnt = model.size();
            check("sweep.count",     32'(bus16.count),     32'(mcnt));
            check("sweep.full",      32'(bus16.full),      32'(mcnt == 16));
            check("sweep.empty",     32'(bus16.empty),     32'(mcnt == 0));
            check("sweep.afull",     32'(bus16.afull),     32'(mcnt >= 12));
            check("sweep.overflow",  32'(bus16.overflow),  32'(mov));
            check("sweep.underflow", 32'(bus16.underflow), 32'(mun));
        end
        bus16.wr_en = 1'b0; bus16.rd_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cdma_sync_fifo.md
Name: cdma_sync_fifo

Overview:
- Parametrised single-clock FIFO for router input/output port buffering. Replaces the fixed 4x4 free-running buffer.
- Adds explicit write/read enables, full, empty and almost-full flags, and an occupancy count. A downstream arbiter can apply backpressure and skip idle channels, which saves switching power.
- Adds sticky overflow/underflow error flags and a synchronous flush.

Parameters:
- WIDTH, 4, data word width in bits (>=1).
- DEPTH, 4, number of entries; power of two, >=2.
- AFULL_LVL, 3, count at or above which afull asserts (1..DEPTH).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous clear of contents and error flags.
- wr_en  input  1  write request.
- wr_data  input  WIDTH  write word.
- rd_en  input  1  read request.
- rd_data  output  WIDTH  registered read word.
- rd_valid  output  1  rd_data holds a newly popped word this cycle.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- afull  output  1  count >= AFULL_LVL.
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky: a write was attempted while full.
- underflow  output  1  sticky: a read was attempted while empty.

Behaviour:
- Reset (async, immediate on rst rising, independent of clk):
  - wr_ptr, rd_ptr and count go to 0; rd_data 0; rd_valid 0.
  - overflow 0, underflow 0; empty 1, full 0, afull 0.
  - Memory contents are not reset.
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. No modulo arithmetic.
- Write accept: wr_acc = wr_en & ~full.
  - On accept: mem[wr_ptr] <= wr_data, wr_ptr increments.
  - Write while full: no state change, overflow set.
- Read accept: rd_acc = rd_en & ~empty.
  - On accept: rd_data <= mem[rd_ptr], rd_ptr increments, rd_valid <= 1 next cycle.
  - Otherwise rd_valid <= 0 and rd_data holds its last value.
  - Read while empty: underflow set.
- Read latency is 1 cycle: a word read-accepted at edge N is on rd_data with rd_valid=1 after edge N.
- Write-to-read: a word written at edge N is readable (empty=0) after edge N. The earliest read accept is edge N+1, so data appears after N+1.
- Simultaneous accepted read and write: count is unchanged and both pointers advance.
  - When full, the write is rejected even if a read is accepted that cycle (no pass-through). The read proceeds and count decrements.
  - When empty, the read is rejected and the write proceeds.
- count: +1 on write-only accept, -1 on read-only accept, unchanged otherwise. It never exceeds DEPTH and never goes below 0.
- full, empty and afull are combinational decodes of the registered count, so they are glitch-free relative to inputs.
- flush (sync, highest priority over wr_en/rd_en in the same cycle):
  - Pointers and count go to 0, rd_valid 0, overflow and underflow cleared.
  - rd_data holds its value.
- Sticky flags hold until rst or flush. They are set on the first offending cycle and remain set.
- Reset mid-operation discards all contents. After release, the first write is stored at address 0.
- Storage may use a register array; no bypass path from wr_data to rd_data.

Test Plan:
- Reset/idle (WIDTH=4, DEPTH=4): assert rst mid-cycle, release, hold idle 3 cycles -> empty=1, full=0, count=0, rd_valid=0, rd_data=0, overflow=0, underflow=0.
- Fill and drain:
  - Write 0xA, 0xB, 0xC, 0xD on 4 consecutive edges -> afull=1 after 3rd, full=1 and count=4 after 4th.
  - Then 4 reads -> rd_data 0xA, 0xB, 0xC, 0xD each with rd_valid=1, one cycle after each accept; empty=1 at end.
- Overflow/underflow:
  - Fifth write 0xE while full -> count stays 4, overflow=1, subsequent reads still return 0xA first.
  - Read while empty -> underflow=1, rd_valid=0, rd_data unchanged.
- Simultaneous read and write:
  - At count=2, wr_en=rd_en=1 with wr_data=0x5 for 6 cycles -> count stays 2, pointers wrap past 3->0, output order is preserved.
  - At full, wr_en=rd_en=1 -> write rejected, count=3, overflow=1.
  - At empty, wr_en=rd_en=1 -> read rejected, count=1, underflow=1.
- Flush priority: at count=3 with overflow set, assert flush with wr_en=rd_en=1 -> next cycle count=0, empty=1, overflow=0, rd_valid=0; next write of 0x7 is read back as 0x7.
- Parameter sweep: WIDTH=8, DEPTH=16, AFULL_LVL=12, random wr_en/rd_en at 50% each for 2000 cycles vs scoreboard model -> zero data mismatches; count, full, empty and afull match the model every cycle.
